// File: rtl/dmni_rx_arbiter_pkg.sv
// Shared defaults and helpers for the DMNI receive-side arbiter.
package dmni_rx_arbiter_pkg;

   localparam int unsigned DEF_N_CH        = 3;
   localparam int unsigned DEF_DATA_SIZE   = 32;
   localparam int unsigned DEF_BUFFER_SIZE = 16;

   // Channel index visited k steps after 'last' in round-robin order.
   function automatic int unsigned rr_index(input int unsigned last,
                                            input int unsigned k,
                                            input int unsigned n);
      return (last + k) % n;
   endfunction

endpackage

// File: rtl/dmni_ring_fifo.sv
// Single-clock ring FIFO; count separates full from empty, flush clears it next cycle.
module dmni_ring_fifo
   import dmni_rx_arbiter_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = DEF_DATA_SIZE,
   parameter int unsigned BUFFER_SIZE = DEF_BUFFER_SIZE,
   localparam int unsigned AW = $clog2(BUFFER_SIZE),
   localparam int unsigned LW = AW + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push,
   output logic                 full,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic                 pop,
   output logic                 empty,
   output logic [DATA_SIZE-1:0] rdata,
   input  logic                 flush,
   output logic [LW-1:0]        count
);

   logic [DATA_SIZE-1:0] mem [BUFFER_SIZE];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == LW'(BUFFER_SIZE));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + LW'(1);
         else if (!do_push && do_pop) count <= count - LW'(1);
      end
   end

   // Storage needs no reset: contents are only observed below a non-zero count.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/dmni_rx_arbiter.sv
// N-channel receive buffer: per-channel ring FIFOs merged by a round-robin arbiter with hold.
module dmni_rx_arbiter
   import dmni_rx_arbiter_pkg::*;
#(
   parameter int unsigned N_CH        = DEF_N_CH,
   parameter int unsigned DATA_SIZE   = DEF_DATA_SIZE,
   parameter int unsigned BUFFER_SIZE = DEF_BUFFER_SIZE,
   localparam int unsigned CW = $clog2(N_CH),
   localparam int unsigned LW = $clog2(BUFFER_SIZE) + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_CH-1:0]           rx_i,
   output logic [N_CH-1:0]           rx_ack_o,
   input  logic [N_CH*DATA_SIZE-1:0] data_i,
   input  logic [N_CH-1:0]           flush_i,
   output logic                      tx_o,
   input  logic                      tx_ack_i,
   output logic [DATA_SIZE-1:0]      data_o,
   output logic [CW-1:0]             tx_ch_o,
   output logic [N_CH*LW-1:0]        level_o
);

   logic [N_CH-1:0]      full;
   logic [N_CH-1:0]      empty;
   logic [N_CH-1:0]      push;
   logic [N_CH-1:0]      pop;
   logic [DATA_SIZE-1:0] rdata [N_CH];
   logic [LW-1:0]        count [N_CH];
   logic [CW-1:0]        rr_last_q;
   logic [CW-1:0]        sel_q;
   logic                 hold_q;
   logic [CW-1:0]        rr_sel;
   logic [CW-1:0]        idx;
   logic [CW-1:0]        sel;
   logic                 rr_found;

   for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
      assign rx_ack_o[c] = !rst_i && !full[c];
      assign push[c]     = rx_i[c] && rx_ack_o[c];
      assign pop[c]      = tx_o && tx_ack_i && (sel == CW'(c));
      assign level_o[c*LW +: LW] = count[c];

      dmni_ring_fifo #(
         .DATA_SIZE   (DATA_SIZE),
         .BUFFER_SIZE (BUFFER_SIZE)
      ) u_fifo (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .push  (push[c]),
         .full  (full[c]),
         .wdata (data_i[c*DATA_SIZE +: DATA_SIZE]),
         .pop   (pop[c]),
         .empty (empty[c]),
         .rdata (rdata[c]),
         .flush (flush_i[c]),
         .count (count[c])
      );
   end

   // First non-empty channel after the last one served.
   always_comb begin
      rr_sel   = rr_last_q;
      rr_found = 1'b0;
      idx      = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         idx = CW'(rr_index(32'(rr_last_q), k, N_CH));
         if (!rr_found && !empty[idx]) begin
            rr_sel   = idx;
            rr_found = 1'b1;
         end
      end
   end

   assign sel     = hold_q ? sel_q : rr_sel;
   assign tx_o    = (|(~empty)) || hold_q;
   assign data_o  = tx_o ? rdata[sel] : '0;
   assign tx_ch_o = tx_o ? sel : '0;

   // A presented but unacked word locks the selection; flushing its channel releases it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_last_q <= CW'(N_CH - 1);
         sel_q     <= '0;
         hold_q    <= 1'b0;
      end else if (tx_o && tx_ack_i) begin
         rr_last_q <= sel;
         hold_q    <= 1'b0;
      end else if (tx_o) begin
         sel_q  <= sel;
         hold_q <= !flush_i[sel];
      end
   end

endmodule

// File: tb/tb_dmni_rx_arbiter.sv
// Randomized + directed scoreboard bench for dmni_rx_arbiter against a queue-based model.
module tb_dmni_rx_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int BS = 16;
   localparam int LW = 5;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    rx_i;
   logic [N-1:0]    rx_ack_o;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    flush_i;
   logic            tx_o;
   logic            tx_ack_i;
   logic [DW-1:0]   data_o;
   logic [CW-1:0]   tx_ch_o;
   logic [N*LW-1:0] level_o;

   always #5 clk = ~clk;

   dmni_rx_arbiter #(.N_CH(N), .DATA_SIZE(DW), .BUFFER_SIZE(BS)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .rx_i     (rx_i),
      .rx_ack_o (rx_ack_o),
      .data_i   (data_i),
      .flush_i  (flush_i),
      .tx_o     (tx_o),
      .tx_ack_i (tx_ack_i),
      .data_o   (data_o),
      .tx_ch_o  (tx_ch_o),
      .level_o  (level_o)
   );

   typedef struct packed {
      logic            tx;
      logic [CW-1:0]   ch;
      logic [DW-1:0]   data;
      logic [N-1:0]    ack;
      logic [N*LW-1:0] lvl;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] mq [N][$];
   int            m_last;
   bit            m_hold;
   int            m_hsel;
   int            checks   = 0;
   int            failures = 0;
   bit            done     = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) mq[c].delete();
      m_last = N - 1;
      m_hold = 1'b0;
      m_hsel = 0;
   endtask

   // Predict this cycle's outputs from the buffered words, then apply this cycle's inputs.
   task automatic model_step();
      exp_t         e;
      bit           tx;
      bit           xfer;
      int           sel;
      bit           found;
      bit [N-1:0]   acc;
      tx = m_hold;
      for (int c = 0; c < N; c++) if (mq[c].size() > 0) tx = 1'b1;
      sel   = 0;
      found = 1'b0;
      if (m_hold) sel = m_hsel;
      else
         for (int k = 1; k <= N; k++)
            if (!found && mq[(m_last + k) % N].size() > 0) begin
               sel   = (m_last + k) % N;
               found = 1'b1;
            end
      e      = '0;
      e.tx   = tx;
      e.ch   = tx ? CW'(sel) : '0;
      e.data = (tx && mq[sel].size() > 0) ? mq[sel][0] : '0;
      for (int c = 0; c < N; c++) begin
         e.ack[c]           = (mq[c].size() < BS);
         e.lvl[c*LW +: LW]  = LW'(mq[c].size());
         acc[c]             = rx_i[c] && (mq[c].size() < BS);
      end
      exp_q.push_back(e);

      xfer = tx && tx_ack_i;
      if (xfer) void'(mq[sel].pop_front());
      for (int c = 0; c < N; c++) begin
         if (flush_i[c]) mq[c].delete();
         else if (acc[c]) mq[c].push_back(data_i[c*DW +: DW]);
      end
      if (xfer) begin
         m_last = sel;
         m_hold = 1'b0;
      end else if (tx) begin
         m_hold = !flush_i[sel];
         m_hsel = sel;
      end
   endtask

   task automatic cyc(input logic [N-1:0] rx, input logic [N*DW-1:0] d,
                      input logic [N-1:0] fl, input logic ack);
      @(negedge clk);
      rx_i     = rx;
      data_i   = d;
      flush_i  = fl;
      tx_ack_i = ack;
      #2;
      model_step();
   endtask

   function automatic logic [N*DW-1:0] dch(input int c, input logic [DW-1:0] v);
      logic [N*DW-1:0] r;
      r = '0;
      r[c*DW +: DW] = v;
      return r;
   endfunction

   task automatic idle(input int n, input logic ack);
      for (int i = 0; i < n; i++) cyc('0, '0, '0, ack);
   endtask

   // Monitor: compares every cycle's DUT outputs against the oldest prediction.
   initial begin : monitor
      exp_t e;
      while (!done) begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_o", 64'(tx_o), 64'(e.tx));
            check("rx_ack_o", 64'(rx_ack_o), 64'(e.ack));
            check("level_o", 64'(level_o), 64'(e.lvl));
            if (e.tx) begin
               check("tx_ch_o", 64'(tx_ch_o), 64'(e.ch));
               check("data_o", 64'(data_o), 64'(e.data));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst      = 1'b1;
      rx_i     = '0;
      data_i   = '0;
      flush_i  = '0;
      tx_ack_i = 1'b0;
      model_reset();
      #1;
      check("rst_rx_ack", 64'(rx_ack_o), 64'(0));
      check("rst_tx_o", 64'(tx_o), 64'(0));
      check("rst_level", 64'(level_o), 64'(0));
      check("rst_data_o", 64'(data_o), 64'(0));
      check("rst_tx_ch", 64'(tx_ch_o), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single word on ch1.
      cyc(3'b010, dch(1, 32'hA0), '0, 1'b0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Fill ch0, push+pop on full, then drain back-to-back.
      for (int i = 0; i < BS; i++) cyc(3'b001, dch(0, DW'(i)), '0, 1'b0);
      cyc(3'b001, dch(0, 32'h99), '0, 1'b1);
      idle(BS + 1, 1'b1);

      // Two words per channel, round-robin drain.
      cyc(3'b111, {32'h21, 32'h11, 32'h01}, '0, 1'b0);
      cyc(3'b111, {32'h22, 32'h12, 32'h02}, '0, 1'b0);
      idle(7, 1'b1);

      // Hold on ch2 while ch0 becomes non-empty.
      cyc(3'b100, dch(2, 32'hC2), '0, 1'b0);
      idle(2, 1'b0);
      cyc(3'b001, dch(0, 32'hC0), '0, 1'b0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      // Flush ch1 with simultaneous push and pop.
      for (int i = 0; i < 5; i++) cyc(3'b010, dch(1, 32'hF0 + DW'(i)), '0, 1'b0);
      cyc(3'b010, dch(1, 32'hDEAD), 3'b010, 1'b1);
      idle(3, 1'b1);

      // Asynchronous reset during an active hold.
      for (int i = 0; i < 3; i++) cyc(3'b001, dch(0, 32'hE0 + DW'(i)), '0, 1'b0);
      cyc(3'b100, dch(2, 32'hE9), '0, 1'b0);
      idle(1, 1'b0);
      rx_i = '0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_tx_o", 64'(tx_o), 64'(0));
      check("arst_level", 64'(level_o), 64'(0));
      check("arst_rx_ack", 64'(rx_ack_o), 64'(0));
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc(3'b101, {32'hB2, 32'h0, 32'hB0}, '0, 1'b0);
      idle(1, 1'b0);
      idle(3, 1'b1);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 2000; i++) begin
         logic [N-1:0] fl;
         fl = '0;
         if ($urandom_range(0, 15) == 0) fl[$urandom_range(0, N - 1)] = 1'b1;
         cyc(N'($urandom), {$urandom, $urandom, $urandom}, fl, ($urandom_range(0, 9) < 6));
      end
      idle(3 * BS + 4, 1'b1);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
